// File: rtl/lif_spike_rate_decoder.sv
// lif_spike_rate_decoder: counts spike rising edges over a programmable window and publishes the rate.
// Define LIF_ISI_EN to also measure the inter-spike interval.
module lif_spike_rate_decoder #(
    parameter int WINDOW_W = 8,
    parameter int COUNT_W  = 8,
    parameter int ISI_W    = 12
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic                spike_in,
    input  logic [WINDOW_W-1:0] window_len,
    output logic [COUNT_W-1:0]  rate_out,
    output logic                rate_valid,
    output logic [ISI_W-1:0]    isi_out,
    output logic                isi_valid
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_nx;
    logic spike_prev, spike_ev, last;
    logic [WINDOW_W-1:0] win_cnt, win_len_q;
    logic [COUNT_W-1:0] spike_cnt, spike_sum;

    assign spike_ev  = spike_in & ~spike_prev;
    assign last      = win_cnt == win_len_q;
    assign spike_sum = (spike_ev && spike_cnt != '1) ? spike_cnt + 1'b1 : spike_cnt;

    always_comb begin
        state_nx = state;
        state_nx = ena ? RUN : IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            spike_prev <= 1'b0;
            win_cnt    <= '0;
            win_len_q  <= '0;
            spike_cnt  <= '0;
            rate_out   <= '0;
            rate_valid <= 1'b0;
        end else begin
            state      <= state_nx;
            spike_prev <= spike_in;
            rate_valid <= 1'b0;
            if (state == IDLE) begin
                win_cnt   <= '0;
                spike_cnt <= '0;
                if (ena) win_len_q <= window_len;
            end else if (ena) begin
                if (last) begin
                    rate_out   <= spike_sum;
                    rate_valid <= 1'b1;
                    spike_cnt  <= '0;
                    win_cnt    <= '0;
                    win_len_q  <= window_len;
                end else begin
                    win_cnt   <= win_cnt + 1'b1;
                    spike_cnt <= spike_sum;
                end
            end
        end
    end

`ifdef LIF_ISI_EN
    logic armed;
    logic [ISI_W-1:0] isi_cnt;

    // the first event after IDLE only arms; later events publish the interval
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed     <= 1'b0;
            isi_cnt   <= '0;
            isi_out   <= '0;
            isi_valid <= 1'b0;
        end else begin
            isi_valid <= 1'b0;
            if (state == IDLE) begin
                armed <= 1'b0;
            end else if (ena) begin
                if (spike_ev) begin
                    armed   <= 1'b1;
                    isi_cnt <= ISI_W'(1);
                    if (armed) begin
                        isi_out   <= isi_cnt;
                        isi_valid <= 1'b1;
                    end
                end else if (isi_cnt != '1) begin
                    isi_cnt <= isi_cnt + 1'b1;
                end
            end
        end
    end
`else
    assign isi_out   = '0;
    assign isi_valid = 1'b0;
`endif
endmodule

// File: tb/tb_lif_spike_rate_decoder.sv
// tb_lif_spike_rate_decoder: directed and random checks of the rate decoder against an event-level model.
// Two instances share stimulus: default widths and COUNT_W=2 for saturation.
module tb_lif_spike_rate_decoder;
`ifdef LIF_ISI_EN
    localparam int ISI_ON = 1;
`else
    localparam int ISI_ON = 0;
`endif
    logic clk = 1'b0, rst_n = 1'b0, ena = 1'b0, spike = 1'b0;
    logic [7:0] wl = 8'd0;
    logic [7:0] rate8;
    logic [1:0] rate2;
    logic rv8, rv2, iv8, iv2;
    logic [11:0] isi8, isi2;
    int tests = 0, fails = 0;

    bit m_prev = 0, m_run = 0, m_armed = 0, m_rv = 0, m_iv = 0, m_evt = 0;
    int m_len = 0, m_pos = 0, m_ev = 0, m_rate = 0, m_isi = 0, m_tick = 0, m_last = 0;

    always #5 clk = ~clk;

    lif_spike_rate_decoder dut8 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .spike_in(spike), .window_len(wl),
        .rate_out(rate8), .rate_valid(rv8), .isi_out(isi8), .isi_valid(iv8)
    );
    lif_spike_rate_decoder #(.COUNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .spike_in(spike), .window_len(wl),
        .rate_out(rate2), .rate_valid(rv2), .isi_out(isi2), .isi_valid(iv2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // model: windows are spans of cycles, rate is the number of rising edges seen, ISI is a timestamp difference
    task automatic model_step();
        if (!rst_n) begin
            m_prev = 0; m_run = 0; m_armed = 0; m_rv = 0; m_iv = 0;
            m_len = 0; m_pos = 0; m_ev = 0; m_rate = 0; m_isi = 0; m_tick = 0; m_last = 0;
        end else begin
            m_evt = spike && !m_prev;
            m_prev = spike;
            m_rv = 0;
            m_iv = 0;
            if (!m_run) begin
                if (ena) begin
                    m_run = 1; m_len = wl; m_pos = 0; m_ev = 0; m_tick = 0; m_armed = 0;
                end
            end else if (!ena) begin
                m_run = 0;
            end else begin
                m_ev += int'(m_evt);
                if (m_pos == m_len) begin
                    m_rate = m_ev; m_rv = 1; m_ev = 0; m_pos = 0; m_len = wl;
                end else begin
                    m_pos++;
                end
                if (m_evt) begin
                    if (m_armed) begin
                        m_isi = (m_tick - m_last > 4095) ? 4095 : m_tick - m_last;
                        m_iv = 1;
                    end
                    m_armed = 1;
                    m_last = m_tick;
                end
                m_tick++;
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) model_step();

    always @(negedge clk) begin
        check("rate8", rate8, m_rate > 255 ? 255 : m_rate);
        check("rate2", rate2, m_rate > 3 ? 3 : m_rate);
        check("rv8", rv8, m_rv);
        check("rv2", rv2, m_rv);
        check("isi8", isi8, ISI_ON ? m_isi : 0);
        check("iv8", iv8, ISI_ON ? m_iv : 0);
        check("isi2", isi2, ISI_ON ? m_isi : 0);
    end

    task automatic step(input logic s);
        spike = s;
        @(negedge clk);
    endtask

    task automatic start(input int w);
        ena = 1'b0;
        step(1'b0);
        wl = 8'(w);
        ena = 1'b1;
        step(1'b0);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check("reset_rate", rate8, 0);
        check("reset_rv", rv8, 0);
        rst_n = 1'b1;
        start(9);
        for (int w = 0; w < 3; w++)
            for (int c = 0; c < 10; c++) begin
                step(c % 3 == 0);
                if (w == 0 && c == 4) check("rate_no_pulse", rv8, 0);
                if (w == 0 && c == 9) begin
                    check("rate_win0", rate8, 4);
                    check("rate_win0_valid", rv8, 1);
                end
            end
        start(9);
        for (int c = 0; c < 10; c++) step(c % 3 == 0);
        check("abort_pre_rate", rate8, 4);
        for (int c = 0; c < 5; c++) step(c == 0 || c == 3);
        ena = 1'b0;
        step(1'b0);
        check("abort_rv", rv8, 0);
        check("abort_rate_hold", rate8, 4);
        wl = 8'd3;
        ena = 1'b1;
        step(1'b0);
        for (int c = 0; c < 4; c++) step(c == 1 || c == 3);
        check("reenable_rate", rate8, 2);
        check("reenable_rv", rv8, 1);
        start(29);
        repeat (20) step(1'b1);
        repeat (10) step(1'b0);
        check("level_rate", rate8, 1);
        start(9);
        for (int c = 0; c < 10; c++) step(c % 2 == 0);
        check("sat_rate8", rate8, 5);
        check("sat_rate2", rate2, 3);
        start(9);
        for (int c = 0; c < 5; c++) step(c == 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rate", rate8, 0);
        check("async_rv", rv8, 0);
        check("async_isi", isi8, 0);
        check("async_iv", iv8, 0);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (!rv8 && n < 50) begin
            step(1'b0);
            n++;
        end
        check("first_rv_latency", n, 11);
        start(255);
        for (int t = 0; t <= 5020; t++) begin
            step(t == 10 || t == 15 || t == 17 || t == 5017);
            if (t == 10) check("isi_first_no_valid", iv8, 0);
            if (t == 15) begin
                check("isi_5", isi8, ISI_ON ? 5 : 0);
                check("isi_5_valid", iv8, ISI_ON ? 1 : 0);
            end
            if (t == 17) check("isi_2", isi8, ISI_ON ? 2 : 0);
            if (t == 5017) check("isi_sat", isi8, ISI_ON ? 4095 : 0);
        end
        repeat (3000) begin
            ena = $urandom_range(0, 29) != 0;
            if ($urandom_range(0, 19) == 0) wl = 8'($urandom_range(0, 12));
            spike = $urandom_range(0, 2) == 0;
            if ($urandom_range(0, 299) == 0) begin
                #2 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
            @(negedge clk);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
